// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: Wishbone slave that buffers byte writes in a small FIFO and
// sends them as 8N1 frames on uart_txd_o. tx_irq_o is a level interrupt that
// is high while the transmitter is idle with an empty FIFO and irq_en is set.
module uart_tx_fifo #(
  parameter int CLK_PERIOD_NS = 20,
  parameter int BAUD_RATE     = 115200,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] data_o,
  output logic        uart_txd_o,
  output logic        tx_irq_o
);

  // Clock cycles per bit, truncated.
  localparam int DIVISOR = 1_000_000_000 / (CLK_PERIOD_NS * BAUD_RATE);
  // The guard keeps the width legal even for an illegal DIVISOR, so that
  // the elaboration error below is the message the user actually sees.
  localparam int BW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0]    ADDR_TXDATA = 4'h0;
  localparam logic [3:0]    ADDR_STATUS = 4'h4;
  localparam logic [3:0]    ADDR_CTRL   = 4'h8;
  localparam logic [BW-1:0] BAUD_LOAD   = BW'(DIVISOR - 1);

  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $fatal(1, "uart_tx_fifo: clock/baud ratio gives DIVISOR < 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  // Transmitter state
  state_t        state, state_d;
  logic [7:0]    shift, shift_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [BW-1:0] baud, baud_d;
  logic          baud_done, txd_d;

  // Bus side
  logic          req, hit_tx, hit_st, hit_ct, bus_err;
  logic          irq_en;
  logic [3:0]    cnt_sat;
  logic [31:0]   status, rdata;

  // Only the low byte lane carries anything for this block.
  logic unused_bits;
  assign unused_bits = ^{data_i[31:8], sel_i[3:1]};

  // Full/empty always come from the count at the start of the cycle, so a
  // same-cycle pop never makes room for a push and vice versa.
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A request is accepted only while no response is on the bus; this keeps a
  // request held through its response cycle from being taken twice.
  assign req = cyc_i & stb_i & ~ack_o & ~err_o;

  // Address decode, error detection, push qualification and read mux
  always_comb begin
    hit_tx  = (addr_i == ADDR_TXDATA);
    hit_st  = (addr_i == ADDR_STATUS);
    hit_ct  = (addr_i == ADDR_CTRL);
    cnt_sat = (32'(count) > 32'd15) ? 4'hF : 4'(count);
    status  = {24'd0, cnt_sat, 1'b0, (state != IDLE), empty, full};
    bus_err = req & (~(hit_tx | hit_st | hit_ct) | (hit_tx & we_i & sel_i[0] & full));
    push    = req & hit_tx & we_i & sel_i[0] & ~full;
    rdata   = '0;
    if (hit_st) rdata = status;
    if (hit_ct) rdata = {31'd0, irq_en};
  end

  // Single-cycle response registers and the CTRL register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      data_o <= '0;
      irq_en <= 1'b0;
    end else begin
      ack_o  <= req & ~bus_err;
      err_o  <= bus_err;
      data_o <= (req & ~bus_err & ~we_i) ? rdata : '0;
      if (req & we_i & hit_ct & sel_i[0]) irq_en <= data_i[0];
    end
  end

  // FIFO storage write port; contents need no reset since count gates reads
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i[7:0];
  end

  // FIFO pointers and occupancy; a simultaneous push and pop cancel out
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transmitter state registers; txd is registered from the next state so
  // the pin changes on the same edge the FSM moves.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      baud       <= '0;
      uart_txd_o <= 1'b1;
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      bit_cnt    <= bit_cnt_d;
      baud       <= baud_d;
      uart_txd_o <= txd_d;
    end
  end

  // Transmitter next-state: each non-idle state lasts DIVISOR cycles per bit
  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    baud_d    = baud;
    pop       = 1'b0;
    baud_done = (baud == '0);
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr];
          bit_cnt_d = '0;
          baud_d    = BAUD_LOAD;
          state_d   = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = BAUD_LOAD;
          state_d = DATA;
        end else begin
          baud_d = baud - BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d    = BAUD_LOAD;
          shift_d   = shift >> 1;
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud - BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop       = 1'b1;
            shift_d   = mem[rd_ptr];
            bit_cnt_d = '0;
            baud_d    = BAUD_LOAD;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Drain interrupt, registered from the current-cycle condition
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tx_irq_o <= 1'b0;
    else          tx_irq_o <= irq_en & empty & (state == IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: DIVISOR 10, FIFO depth 8. Bus responses and
// transmitted bytes are queued as expectations by the stimulus and checked
// by independent monitors; timing-critical points are checked inline.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam logic [3:0] A_TX = 4'h0;
  localparam logic [3:0] A_ST = 4'h4;
  localparam logic [3:0] A_CT = 4'h8;

  logic        clk = 1'b0;
  logic        rst_n, stb, cyc, we;
  logic [3:0]  addr, sel;
  logic [31:0] wdata;
  logic        ack, err, txd, irq;
  logic [31:0] rdata;

  always #10 clk = ~clk;

  uart_tx_fifo #(.CLK_PERIOD_NS(20), .BAUD_RATE(5_000_000), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stb_i(stb), .cyc_i(cyc), .addr_i(addr),
    .data_i(wdata), .sel_i(sel), .we_i(we), .ack_o(ack), .err_o(err),
    .data_o(rdata), .uart_txd_o(txd), .tx_irq_o(irq)
  );

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] data;
    logic [31:0] cyc;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [7:0]  line_q[$];
  int unsigned start_q[$];
  int unsigned cycnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cycnt <= cycnt + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // One bus request; returns 1ns into the response cycle (N+1).
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic e_err, input logic [31:0] e_data);
    bus_exp_t e;
    e.ack = ~e_err; e.err = e_err; e.data = e_data; e.cyc = cycnt + 1;
    bus_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 4'hF, 1'b0, 32'h0); idle();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    bus(1'b0, a, 32'h0, 4'hF, 1'b0, e); idle();
  endtask

  // Bus monitor: every ack/err must match the next queued response and cycle.
  initial begin
    bus_exp_t e;
    logic prev_resp;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (ack || err) begin
        if (bus_q.size() == 0) check("bus_unexpected", {ack, err}, 2'b00);
        else begin
          e = bus_q.pop_front();
          check("bus_resp", {ack, err, rdata, cycnt}, {e.ack, e.err, e.data, e.cyc});
        end
      end else if (prev_resp) begin
        check("data_idle", rdata, 32'h0);
      end
      prev_resp = ack || err;
    end
  end

  // Line monitor: decode 8N1 frames sampling mid-bit, compare to queued bytes.
  initial begin
    logic [9:0] bits;
    logic       ab;
    logic [7:0] eb;
    int unsigned s;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        s = cycnt;
        start_q.push_back(s);
        ab = 1'b0;
        bits = '1;
        for (int k = 1; k < 100; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin ab = 1'b1; break; end
          if (k % 10 == 5) bits[k/10] = txd;
        end
        if (!ab) begin
          check("frame_start_bit", bits[0], 1'b0);
          check("frame_stop_bit", bits[9], 1'b1);
          if (line_q.size() == 0) check("frame_unexpected", 1'b1, 1'b0);
          else begin
            eb = line_q.pop_front();
            check("frame_byte", bits[8:1], eb);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [99:0] got, expv;
    logic [9:0]  pat;
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    #2 rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_outputs", {txd, ack, err, irq, rdata}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1 rst_n = 1'b1;
    idle();
    rd(A_ST, 32'h2);
    rd(A_CT, 32'h0);

    // Reset in the middle of a frame (0x3C: bit1 is 0 at this point)
    line_q.push_back(8'h3C);
    wr(A_TX, 32'h3C);
    repeat (20) @(posedge clk);
    #3;
    check("pre_reset_txd_low", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_txd_async", txd, 1'b1);
    line_q.delete();
    repeat (2) @(negedge clk);
    check("reset_mid_outputs", {txd, ack, err, irq, rdata}, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1 rst_n = 1'b1;
    idle();
    rd(A_ST, 32'h2);

    // Single frame 0xA5: start, LSB first, stop
    pat = 10'b1101001010;
    for (int k = 0; k < 100; k++) expv[k] = pat[k/10];
    line_q.push_back(8'hA5);
    bus(1'b1, A_TX, 32'hA5, 4'h1, 1'b0, 32'h0);
    @(negedge clk); check("txd_high_n1", txd, 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      got[k] = txd;
    end
    check("frame_a5_waveform", got, expv);
    @(negedge clk); check("line_idle_after", txd, 1'b1);
    idle();

    // Bad accesses, ignored writes, held request
    bus(1'b0, 4'hC, 32'h0, 4'hF, 1'b1, 32'h0); idle();
    wr(A_ST, 32'hFFFF_FFFF);
    rd(A_ST, 32'h2);
    bus(1'b1, A_TX, 32'h77, 4'hE, 1'b0, 32'h0); idle();
    rd(A_ST, 32'h2);
    rd(A_TX, 32'h0);
    begin
      bus_exp_t e;
      e.ack = 1'b1; e.err = 1'b0; e.data = 32'h2; e.cyc = cycnt + 1;
      bus_q.push_back(e);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = A_ST; sel = 4'hF;
      idle(); idle();
      cyc = 1'b0; stb = 1'b0; addr = '0; sel = '0;
      idle();
    end

    // Interrupt
    bus(1'b1, A_CT, 32'h1, 4'hF, 1'b0, 32'h0);
    @(negedge clk); check("irq_n1_low", irq, 1'b0);
    @(negedge clk); check("irq_n2_high", irq, 1'b1);
    idle();
    rd(A_CT, 32'h1);
    line_q.push_back(8'hC3);
    bus(1'b1, A_TX, 32'hC3, 4'h1, 1'b0, 32'h0);
    @(negedge clk); check("irq_push_n1", irq, 1'b1);
    @(negedge clk); check("irq_push_n2", irq, 1'b0);
    repeat (100) @(negedge clk);
    check("irq_stop_end", irq, 1'b0);
    @(negedge clk); check("irq_reassert", irq, 1'b1);
    idle();
    bus(1'b1, A_CT, 32'h0, 4'hF, 1'b0, 32'h0);
    @(negedge clk); check("irq_clr_n1", irq, 1'b1);
    @(negedge clk); check("irq_clr_n2", irq, 1'b0);
    idle();

    // Back-to-back frames with zero gap
    start_q.delete();
    line_q.push_back(8'h55);
    line_q.push_back(8'hFF);
    wr(A_TX, 32'h55);
    wr(A_TX, 32'hFF);
    repeat (215) @(posedge clk);
    #1;
    check("b2b_frame_count", start_q.size(), 2);
    if (start_q.size() >= 2) check("b2b_gap", start_q[1] - start_q[0], 100);
    rd(A_ST, 32'h2);

    // Overflow: first byte pops, eight fill the FIFO, the tenth errors
    for (int i = 0; i < 10; i++) begin
      if (i < 9) line_q.push_back(8'(i));
      bus(1'b1, A_TX, 32'(i), 4'h1, (i == 9), 32'h0);
      idle();
    end
    rd(A_ST, 32'h85);
    repeat (950) @(posedge clk);
    #1;
    rd(A_ST, 32'h2);

    check("bus_q_drained", bus_q.size(), 0);
    check("line_q_drained", line_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
